// File: rtl/common_pkg.sv
// Shared types and constants for the CLIC dispatch slice.
package common_pkg;

    localparam int NR_INDEX_BITS = 8;
    typedef logic [NR_INDEX_BITS-1:0] Index;

    // All-ones index: "threshold won" from the arbiter, "nothing active" as threshold
    localparam Index INDEX_NONE = '1;

    // Maximum number of nested (preempted) active interrupts
    localparam int NEST_DEPTH = 4;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        ACTIVE
    } dispatch_state_e;

endpackage

// File: rtl/clic_nest_stack.sv
// LIFO of active interrupt indices; top is the innermost handler, all-ones when empty.
module clic_nest_stack
    import common_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic             pop,
    input  Index             data,
    output Index             top,
    output logic [CNT_W-1:0] depth,
    output logic             full,
    output logic             empty
);

    Index             mem [DEPTH];
    logic [CNT_W-1:0] count;

    // Push writes the slot just above the current top; pop only moves the count
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (push && !full) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (CNT_W'(i) == count) begin
                    mem[i] <= data;
                end
            end
            count <= count + 1'b1;
        end else if (pop && !empty) begin
            count <= count - 1'b1;
        end
    end

    // Select the most recently pushed entry, or all-ones when nothing is stored
    always_comb begin
        top = INDEX_NONE;
        for (int i = 0; i < DEPTH; i++) begin
            if (CNT_W'(i + 1) == count) begin
                top = mem[i];
            end
        end
    end

    assign depth = count;
    assign full  = (count == CNT_W'(DEPTH));
    assign empty = (count == '0);

endmodule

// File: rtl/clic_dispatch.sv
// CLIC dispatch: offers arbiter winners to the core, tracks nested active handlers.
// Optional feature macro: CLIC_NEST_EN (nesting up to NEST_DEPTH); when undefined
// only one handler can be active and the stack collapses to a single register.
module clic_dispatch
    import common_pkg::*;
#(
    parameter int NEST_DEPTH = common_pkg::NEST_DEPTH
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            is_interrupt,
    input  Index                            index,
    output logic                            irq_valid,
    input  logic                            irq_ready,
    output Index                            irq_id,
    input  logic                            complete,
    output logic                            clear_pending,
    output Index                            clear_index,
    output Index                            active_index,
    output logic [$clog2(NEST_DEPTH+1)-1:0] depth,
    output logic                            err
);

    localparam int DW = $clog2(NEST_DEPTH + 1);
`ifdef CLIC_NEST_EN
    localparam int EFF_DEPTH = NEST_DEPTH;
`else
    localparam int EFF_DEPTH = 1;
`endif

    dispatch_state_e state, state_next;
    logic            load_id;
    logic            push;
    logic            pop;
    logic            clear_next;
    logic            err_set;
    logic            int_ok;
    logic            full;
    logic            empty;

    // With an effective depth of 1 the stack is full whenever a handler is
    // active, so the same preemption rule also blocks nesting in that build.
    clic_nest_stack #(
        .DEPTH (EFF_DEPTH),
        .CNT_W (DW)
    ) u_stack (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .pop   (pop),
        .data  (irq_id),
        .top   (active_index),
        .depth (depth),
        .full  (full),
        .empty (empty)
    );

    assign int_ok    = is_interrupt && (index != INDEX_NONE);
    assign irq_valid = (state == REQ);

    // Next-state and control decode; complete has priority over a new request
    always_comb begin
        state_next = state;
        load_id    = 1'b0;
        push       = 1'b0;
        pop        = 1'b0;
        clear_next = 1'b0;
        err_set    = complete && ((state == REQ) || empty);
        case (state)
            IDLE: begin
                if (int_ok) begin
                    load_id    = 1'b1;
                    state_next = REQ;
                end
            end
            REQ: begin
                if (irq_ready) begin
                    push       = 1'b1;
                    clear_next = 1'b1;
                    state_next = ACTIVE;
                end
            end
            ACTIVE: begin
                if (complete) begin
                    pop = 1'b1;
                    if (depth == DW'(1)) begin
                        state_next = IDLE;
                    end
                end else if (int_ok && !full) begin
                    load_id    = 1'b1;
                    state_next = REQ;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // State, offered id, clear pulse and sticky error registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            irq_id        <= '0;
            clear_pending <= 1'b0;
            clear_index   <= '0;
            err           <= 1'b0;
        end else begin
            state         <= state_next;
            clear_pending <= clear_next;
            err           <= err | err_set;
            if (load_id) begin
                irq_id <= index;
            end
            if (clear_next) begin
                clear_index <= irq_id;
            end
        end
    end

endmodule

// File: tb/tb_clic_dispatch.sv
// Testbench for clic_dispatch: directed scenarios plus random traffic against a queue model.
module tb_clic_dispatch;
    import common_pkg::*;

`ifdef CLIC_NEST_EN
    localparam int EFF = NEST_DEPTH;
`else
    localparam int EFF = 1;
`endif
    localparam int DW = $clog2(NEST_DEPTH + 1);
    localparam Index NONE = 8'hFF;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          is_interrupt = 1'b0;
    Index          index = '0;
    logic          irq_ready = 1'b0;
    logic          complete = 1'b0;
    logic          irq_valid;
    Index          irq_id;
    logic          clear_pending;
    Index          clear_index;
    Index          active_index;
    logic [DW-1:0] depth;
    logic          err;

    int total = 0;
    int bad = 0;

    // Reference model: an offer in flight, a queue of active ids, pulse and error flags
    bit   m_offer;
    Index m_id;
    Index m_stk[$];
    bit   m_clr;
    Index m_clr_idx;
    bit   m_err;

    clic_dispatch #(.NEST_DEPTH(NEST_DEPTH)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .is_interrupt  (is_interrupt),
        .index         (index),
        .irq_valid     (irq_valid),
        .irq_ready     (irq_ready),
        .irq_id        (irq_id),
        .complete      (complete),
        .clear_pending (clear_pending),
        .clear_index   (clear_index),
        .active_index  (active_index),
        .depth         (depth),
        .err           (err)
    );

    always #5 clk = ~clk;

    function automatic Index m_active();
        if (m_stk.size() == 0) return NONE;
        return m_stk[m_stk.size() - 1];
    endfunction

    task automatic model_reset();
        m_offer = 0; m_id = '0; m_stk.delete(); m_clr = 0; m_clr_idx = '0; m_err = 0;
    endtask

    // One clock of the dispatch rules applied to the inputs seen at the edge
    task automatic model_edge();
        bit want = is_interrupt && (index != NONE);
        m_clr = 0;
        if (m_offer) begin
            if (complete) m_err = 1;
            if (irq_ready) begin
                m_stk.push_back(m_id);
                m_offer = 0;
                m_clr = 1;
                m_clr_idx = m_id;
            end
        end else if (m_stk.size() == 0) begin
            if (complete) m_err = 1;
            if (want) begin m_offer = 1; m_id = index; end
        end else if (complete) begin
            void'(m_stk.pop_back());
        end else if (want && m_stk.size() < EFF) begin
            m_offer = 1;
            m_id = index;
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        model_edge();
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst_n = 0; is_interrupt = 0; index = '0; irq_ready = 0; complete = 0;
        model_reset();
        repeat (2) @(negedge clk);
        rst_n = 1;
    endtask

    task automatic handshake(input Index id);
        is_interrupt = 1; index = id;
        cycle();
        is_interrupt = 0; irq_ready = 1;
        cycle();
        irq_ready = 0;
    endtask

    task automatic test_reset();
        do_reset();
        total++; if (irq_valid !== 1'b0) begin bad++; $display("FAIL reset_irq_valid: got %0h want 0", irq_valid); end
        total++; if (irq_id !== 8'h00) begin bad++; $display("FAIL reset_irq_id: got %0h want 0", irq_id); end
        total++; if (clear_pending !== 1'b0) begin bad++; $display("FAIL reset_clear_pending: got %0h want 0", clear_pending); end
        total++; if (clear_index !== 8'h00) begin bad++; $display("FAIL reset_clear_index: got %0h want 0", clear_index); end
        total++; if (active_index !== NONE) begin bad++; $display("FAIL reset_active_index: got %0h want ff", active_index); end
        total++; if (depth !== '0) begin bad++; $display("FAIL reset_depth: got %0d want 0", depth); end
        total++; if (err !== 1'b0) begin bad++; $display("FAIL reset_err: got %0h want 0", err); end
    endtask

    task automatic test_scenario1();
        do_reset();
        is_interrupt = 1; index = 8'd5;
        cycle();
        is_interrupt = 0;
        total++; if (irq_valid !== 1'b1 || irq_id !== 8'd5) begin bad++; $display("FAIL s1_offer: got valid=%0h id=%0d want valid=1 id=5", irq_valid, irq_id); end
        cycle();
        total++; if (irq_valid !== 1'b1) begin bad++; $display("FAIL s1_hold: got %0h want 1", irq_valid); end
        irq_ready = 1;
        cycle();
        irq_ready = 0;
        total++; if (irq_valid !== 1'b0 || clear_pending !== 1'b1 || clear_index !== 8'd5) begin bad++; $display("FAIL s1_clear: got valid=%0h clr=%0h idx=%0d want 0 1 5", irq_valid, clear_pending, clear_index); end
        total++; if (active_index !== 8'd5 || depth !== DW'(1)) begin bad++; $display("FAIL s1_active: got act=%0d depth=%0d want 5 1", active_index, depth); end
        cycle();
        total++; if (clear_pending !== 1'b0) begin bad++; $display("FAIL s1_pulse_end: got %0h want 0", clear_pending); end
    endtask

    task automatic test_hold();
        do_reset();
        is_interrupt = 1; index = 8'd5;
        cycle();
        for (int i = 0; i < 10; i++) begin
            index = (i < 5) ? 8'd5 + Index'(i % 3) : 8'd7;
            cycle();
            total++; if (irq_valid !== 1'b1 || irq_id !== 8'd5 || clear_pending !== 1'b0) begin bad++; $display("FAIL hold_%0d: got valid=%0h id=%0d clr=%0h want 1 5 0", i, irq_valid, irq_id, clear_pending); end
        end
        is_interrupt = 0;
    endtask

    task automatic test_nest();
        do_reset();
        handshake(8'd5);
        handshake(8'd9);
        total++; if (depth !== DW'(m_stk.size()) || active_index !== m_active()) begin bad++; $display("FAIL nest_push: got depth=%0d act=%0d want %0d %0d", depth, active_index, m_stk.size(), m_active()); end
        complete = 1; cycle(); complete = 0;
        total++; if (active_index !== m_active() || depth !== DW'(m_stk.size())) begin bad++; $display("FAIL nest_pop1: got act=%0d depth=%0d want %0d %0d", active_index, depth, m_active(), m_stk.size()); end
        complete = 1; cycle(); complete = 0;
        total++; if (depth !== '0 || active_index !== NONE || irq_valid !== 1'b0) begin bad++; $display("FAIL nest_pop2: got depth=%0d act=%0h valid=%0h want 0 ff 0", depth, active_index, irq_valid); end
        total++; if (err !== 1'(m_err)) begin bad++; $display("FAIL nest_err: got %0h want %0h", err, m_err); end
    endtask

    task automatic test_complete_and_int();
        do_reset();
        handshake(8'd5);
        complete = 1; is_interrupt = 1; index = 8'd3;
        cycle();
        complete = 0;
        total++; if (depth !== '0 || irq_valid !== 1'b0) begin bad++; $display("FAIL both_pop: got depth=%0d valid=%0h want 0 0", depth, irq_valid); end
        cycle();
        is_interrupt = 0;
        total++; if (irq_valid !== 1'b1 || irq_id !== 8'd3) begin bad++; $display("FAIL both_req: got valid=%0h id=%0d want 1 3", irq_valid, irq_id); end
    endtask

    task automatic test_err_reset();
        do_reset();
        complete = 1; cycle(); complete = 0;
        total++; if (err !== 1'b1) begin bad++; $display("FAIL err_set: got %0h want 1", err); end
        is_interrupt = 1; index = 8'd12;
        repeat (3) cycle();
        total++; if (err !== 1'b1 || irq_valid !== 1'b1) begin bad++; $display("FAIL err_sticky: got err=%0h valid=%0h want 1 1", err, irq_valid); end
        #2 rst_n = 0;
        #1;
        total++; if (irq_valid !== 1'b0 || irq_id !== 8'h00 || clear_pending !== 1'b0 || clear_index !== 8'h00) begin bad++; $display("FAIL async_rst_a: got %0h %0h %0h %0h want 0 0 0 0", irq_valid, irq_id, clear_pending, clear_index); end
        total++; if (active_index !== NONE || depth !== '0 || err !== 1'b0) begin bad++; $display("FAIL async_rst_b: got act=%0h depth=%0d err=%0h want ff 0 0", active_index, depth, err); end
        do_reset();
    endtask

    task automatic test_full();
        do_reset();
        for (int k = 0; k < EFF; k++) handshake(Index'(k + 1));
        total++; if (depth !== DW'(m_stk.size()) || active_index !== m_active()) begin bad++; $display("FAIL full_fill: got depth=%0d act=%0d want %0d %0d", depth, active_index, m_stk.size(), m_active()); end
        is_interrupt = 1; index = 8'd10;
        for (int i = 0; i < 3; i++) begin
            cycle();
            total++; if (irq_valid !== 1'b0) begin bad++; $display("FAIL full_ignore_%0d: got %0h want 0", i, irq_valid); end
        end
        complete = 1; cycle(); complete = 0;
        cycle();
        total++; if (irq_valid !== 1'b1 || irq_id !== 8'd10) begin bad++; $display("FAIL full_after_pop: got valid=%0h id=%0d want 1 10", irq_valid, irq_id); end
        is_interrupt = 0;
    endtask

    task automatic test_random();
        do_reset();
        for (int c = 0; c < 400; c++) begin
            is_interrupt = ($urandom_range(0, 1) == 1);
            index = ($urandom_range(0, 7) == 0) ? NONE : Index'($urandom_range(0, 15));
            irq_ready = ($urandom_range(0, 9) < 3);
            complete = ($urandom_range(0, 9) < 2);
            cycle();
            total++; if (irq_valid !== 1'(m_offer) || (m_offer && irq_id !== m_id)) begin bad++; $display("FAIL rnd_offer@%0d: got valid=%0h id=%0d want %0h %0d", c, irq_valid, irq_id, m_offer, m_id); end
            total++; if (clear_pending !== 1'(m_clr) || (m_clr && clear_index !== m_clr_idx)) begin bad++; $display("FAIL rnd_clear@%0d: got clr=%0h idx=%0d want %0h %0d", c, clear_pending, clear_index, m_clr, m_clr_idx); end
            total++; if (active_index !== m_active() || depth !== DW'(m_stk.size())) begin bad++; $display("FAIL rnd_stack@%0d: got act=%0d depth=%0d want %0d %0d", c, active_index, depth, m_active(), m_stk.size()); end
            total++; if (err !== 1'(m_err)) begin bad++; $display("FAIL rnd_err@%0d: got %0h want %0h", c, err, m_err); end
        end
        is_interrupt = 0; irq_ready = 0; complete = 0;
    endtask

    initial begin
        test_reset();
        test_scenario1();
        test_hold();
        test_nest();
        test_complete_and_int();
        test_err_reset();
        test_full();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/clic_dispatch.md
CLIC_DISPATCH -- requirements
Module: clic_dispatch

Interface
REQ-001 Parameter: NEST_DEPTH, default 4, maximum number of nested (preempted) active interrupts; taken from common_pkg.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset; asynchronous, active-low.
REQ-004 is_interrupt  input  1  arbiter reports a winner above the current threshold.
REQ-005 index  input  Index  arbiter winning index.
REQ-006 irq_valid  output  1  interrupt request to the core.
REQ-007 irq_ready  input  1  core accepts the request.
REQ-008 irq_id  output  Index  index offered to the core; stable while irq_valid is high.
REQ-009 complete  input  1  single-cycle pulse; core finished the innermost handler.
REQ-010 clear_pending  output  1  single-cycle pulse to the entry table to clear the pending bit.
REQ-011 clear_index  output  Index  entry to clear; valid only with clear_pending.
REQ-012 active_index  output  Index  innermost active index, used as threshold; all-ones when none is active.
REQ-013 depth  output  $clog2(NEST_DEPTH+1)  number of active interrupts.
REQ-014 err  output  1  sticky protocol-error flag.

Function
REQ-015 FSM states SHALL be IDLE, REQ and ACTIVE.
REQ-016 IDLE: when is_interrupt=1, latch index into irq_id and go to REQ next cycle; irq_valid=1 from that cycle.
REQ-017 REQ: hold irq_valid=1 and irq_id stable regardless of arbiter changes; on irq_valid&irq_ready, push irq_id, pulse clear_pending with clear_index=irq_id in the following cycle, deassert irq_valid, go to ACTIVE.
REQ-018 Latency from is_interrupt to irq_valid: 1 cycle; from handshake to clear_pending: 1 cycle.
REQ-019 ACTIVE with complete=1: pop; go to IDLE if depth becomes 0, else stay in ACTIVE.
REQ-020 ACTIVE with is_interrupt=1, complete=0 and depth<NEST_DEPTH: latch index, go to REQ (preemption).
REQ-021 ACTIVE with complete=1 and is_interrupt=1 in the same cycle: complete wins; the request is re-evaluated next cycle.
REQ-022 Stack full (depth=NEST_DEPTH): ignore is_interrupt and stay in ACTIVE.
REQ-023 complete while depth=0, or while in REQ: ignored; set err.
REQ-024 index=all-ones with is_interrupt=1 (threshold won): treated as no interrupt.
REQ-025 active_index SHALL update in the cycle after push or pop.

Reset
REQ-026 Asserting rst_n low at any time, including mid-handshake, SHALL immediately force: state=IDLE, irq_valid=0, irq_id=0, clear_pending=0, clear_index=0, active_index=all-ones, depth=0, err=0; stack contents are discarded.

Configuration
REQ-027 CLIC_NEST_EN defined: nesting up to NEST_DEPTH per REQ-020 and REQ-022.
REQ-028 CLIC_NEST_EN undefined: effective depth is 1; ACTIVE ignores is_interrupt until complete; stack reduces to one register.

Structure
REQ-029 common_pkg SHALL hold NEST_DEPTH, the dispatch-state enum, and the existing Index and NR_INDEX_BITS.
REQ-030 The LIFO SHALL be the sub-module clic_nest_stack (push, pop, top, depth, full, empty).

Verification
REQ-031 Scenario 1: is_interrupt=1, index=5, irq_ready=1 two cycles later -> irq_valid held until handshake; clear_pending pulse with clear_index=5; active_index=5; depth=1.
REQ-032 Scenario 2: irq_ready=0 for 10 cycles while arbiter index changes 5->7 -> irq_id stays 5 throughout; no clear_pending.
REQ-033 Scenario 3 (CLIC_NEST_EN): active 5, then index=9 -> second handshake, depth=2, active_index=9; complete -> active_index=5; complete -> depth=0, active_index=all-ones, IDLE.
REQ-034 Scenario 4: complete and is_interrupt together in ACTIVE at depth 1 -> pop first; new REQ starts the following cycle.
REQ-035 Scenario 5: complete with depth=0 -> err=1 and remains 1; rst_n low mid-REQ -> all outputs at reset values within the same cycle.
REQ-036 Scenario 6: NEST_DEPTH=4 filled -> further is_interrupt ignored; irq_valid stays 0; without CLIC_NEST_EN, a second interrupt is ignored until complete.
